sram_tiled_rmw: RTL and testbench
=================================

SRAM_TILED_RMW -- requirements
Module: sram_tiled_rmw

Interface
REQ-001 SHALL have parameter DATA_BIT, default 128; word width, a multiple of 32.
REQ-002 SHALL have parameter DEPTH, default 2048; words, a multiple of MACRO_DEPTH.
REQ-003 SHALL have parameter MACRO_DEPTH, default 512; words per macro, 128 or 512.
REQ-004 SHALL have parameter BWE, default 1; 1 enables bit-masked writes, 0 treats every write as full-word.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1 bit; request present.
REQ-008 SHALL have port req_ready, output, 1 bit; request accepted when req_valid and req_ready are both high at an edge.
REQ-009 SHALL have port req_wen, input, 1 bit; 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, $clog2(DEPTH) bits; word address.
REQ-011 SHALL have port req_bwe, input, DATA_BIT bits; per-bit write enable.
REQ-012 SHALL have port req_wdata, input, DATA_BIT bits; write data.
REQ-013 SHALL have port rsp_valid, output, 1 bit; one-cycle pulse per accepted read.
REQ-014 SHALL have port rsp_rdata, output, DATA_BIT bits; read data, held until the next response.

Function
REQ-015 SHALL split storage into NUM_TILES = DEPTH/MACRO_DEPTH tiles × NUM_BANKS = DATA_BIT/32 banks of 32-bit single-port macros.
- addr low $clog2(MACRO_DEPTH) bits = local address; upper bits = tile select.
- NUM_TILES = 1 needs no select bits.
REQ-016 SHALL enable (csb low) only the selected tile's macros in any cycle; all other macros idle.
REQ-017 SHALL have states IDLE and MERGE.
REQ-018 SHALL, in IDLE, hold req_ready high and drive the macros combinationally from the request in the acceptance cycle.
REQ-019 SHALL give reads a fixed 2-cycle latency.
- Read accepted at edge E0: rsp_valid high in the cycle after edge E1.
- rsp_rdata is registered from the selected tile's dout.
- Back-to-back reads sustain 1 per cycle.
REQ-020 SHALL complete a full write (BWE=0 or req_bwe all ones) at the acceptance edge, with no response and the state staying in IDLE.
REQ-021 SHALL perform a partial write (BWE=1, req_bwe not all ones) as read-modify-write.
- Acceptance edge: macro read; addr, bwe and wdata captured; go to MERGE.
- MERGE: req_ready low; macro written with (dout & ~bwe) | (wdata & bwe); return to IDLE at the next edge.
- Throughput: 1 per 2 cycles; no response.
REQ-022 SHALL overlap a read accepted the cycle before a partial write: the read's response is unaffected and is produced at its normal latency.
REQ-023 SHALL return the merged data for a read accepted the cycle after MERGE, with no stale-data hazard.
REQ-024 SHALL keep rsp_rdata unchanged when rsp_valid is low.
REQ-025 SHALL ignore req_* fields while req_valid is low, with no macro access.
REQ-026 SHALL wrap the top address (DEPTH-1) to no other location; the address range is exact.

Reset
REQ-027 SHALL, while rst is high: state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, all csb high.
REQ-028 SHALL drop a partial write pending in MERGE when reset is asserted; the macro keeps its old contents.
REQ-029 SHALL not produce a response for a read in flight at reset.
REQ-030 SHALL raise req_ready in the first cycle after rst deasserts.

Structure
REQ-031 SHALL take MACRO_WIDTH = 32 and the state enum {IDLE, MERGE} from shared package sram_pkg.
REQ-032 SHALL instantiate one sub-module, sram_macro_sp: 1-cycle-read behavioural/blackbox macro wrapper with ports clk, csb, web, addr, din, dout, depth-parameterised to select the 128- or 512-word macro.

Verification
REQ-033 SHALL check full write then read: write 0xAAAA…A to addr 5, read addr 5 -> rsp_valid 2 cycles after read accept, rdata = 0xAAAA…A.
REQ-034 SHALL check partial write: preload addr 600 = all ones, write wdata 0, bwe = 0x0000_00FF in low bank -> req_ready low 1 cycle; read -> low 8 bits 0, rest ones.
REQ-035 SHALL check tile isolation: write distinct values to addr 3 and addr 515 (DEPTH 2048, MACRO_DEPTH 512) -> each read returns its own value; other tiles' csb stays high.
REQ-036 SHALL check back-to-back traffic: read A, partial write A, read A on consecutive accepts -> first rdata = old, second = merged, rsp_valid pulses exactly twice.
REQ-037 SHALL check reset in MERGE: assert rst during MERGE of a write to addr 7 (old 0x1234) -> after reset, read addr 7 returns 0x1234, rsp_valid 0 during reset.
REQ-038 SHALL check BWE=0 build: partial bwe mask with wdata 0x55…5 -> whole word written, no MERGE cycle.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the tiled SRAM: macro width, controller state encoding
// and the per-bit merge used by the read-modify-write path.
package sram_pkg;

    localparam int MACRO_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

    // Keep old bits where bwe is clear, take new bits where it is set.
    function automatic logic [MACRO_WIDTH-1:0] merge_word(
        input logic [MACRO_WIDTH-1:0] old_data,
        input logic [MACRO_WIDTH-1:0] new_data,
        input logic [MACRO_WIDTH-1:0] bwe
    );
        return (old_data & ~bwe) | (new_data & bwe);
    endfunction

endpackage

// File: rtl/sram_macro_sp.sv
// Behavioural stand-in for a 32-bit single-port SRAM macro (128 or 512 words).
// One-cycle read; dout holds its value on writes and idle cycles.
module sram_macro_sp
    import sram_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     csb,
    input  logic                     web,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [MACRO_WIDTH-1:0]   din,
    output logic [MACRO_WIDTH-1:0]   dout
);

    logic [MACRO_WIDTH-1:0] mem [DEPTH];

    // Active-low chip select and write enable, as on the hard macro.
    always_ff @(posedge clk) begin
        if (!csb) begin
            if (!web) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sram_tiled_rmw.sv
// Wide SRAM built from tiles x banks of 32-bit single-port macros, with bit-masked
// writes done as a two-cycle read-modify-write. Valid/ready: a request transfers on
// any rising edge where req_valid and req_ready are both high; rsp_valid is a one-cycle pulse.
module sram_tiled_rmw
    import sram_pkg::*;
#(
    parameter int DATA_BIT    = 128,
    parameter int DEPTH       = 2048,
    parameter int MACRO_DEPTH = 512,
    parameter int BWE         = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_wen,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [DATA_BIT-1:0]      req_bwe,
    input  logic [DATA_BIT-1:0]      req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_BIT-1:0]      rsp_rdata,
    output state_t                   dbg_state
);

    localparam int NUM_TILES = DEPTH / MACRO_DEPTH;
    localparam int NUM_BANKS = DATA_BIT / MACRO_WIDTH;
    localparam int LAW       = $clog2(MACRO_DEPTH);
    localparam int TSW       = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

    state_t                 state;
    logic                   accept;
    logic                   req_full;
    logic [TSW-1:0]         req_tile;
    logic [NUM_TILES-1:0]   tile_csb;
    logic                   mac_web;
    logic [LAW-1:0]         mac_addr;
    logic [DATA_BIT-1:0]    mac_din;
    logic [DATA_BIT-1:0]    merged;
    logic [DATA_BIT-1:0]    tile_dout [NUM_TILES];

    logic                   rd_pending;
    logic [TSW-1:0]         rd_tile;
    logic [TSW-1:0]         cap_tile;
    logic [LAW-1:0]         cap_addr;
    logic [DATA_BIT-1:0]    cap_bwe;
    logic [DATA_BIT-1:0]    cap_wdata;

    assign accept    = req_valid && req_ready;
    assign req_full  = (BWE == 0) || (&req_bwe);
    assign req_tile  = TSW'(req_addr >> LAW);
    assign dbg_state = state;

    always_comb begin
        merged = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            merged[b*MACRO_WIDTH +: MACRO_WIDTH] = merge_word(
                tile_dout[cap_tile][b*MACRO_WIDTH +: MACRO_WIDTH],
                cap_wdata[b*MACRO_WIDTH +: MACRO_WIDTH],
                cap_bwe[b*MACRO_WIDTH +: MACRO_WIDTH]);
        end
    end

    // Address and data are shared by every tile; only the selected tile's csb drops.
    // Reset gates all access so a pending merge never reaches the array.
    always_comb begin
        tile_csb = '1;
        mac_web  = 1'b1;
        mac_addr = req_addr[LAW-1:0];
        mac_din  = req_wdata;
        if (!rst) begin
            if (state == MERGE) begin
                tile_csb[cap_tile] = 1'b0;
                mac_web            = 1'b0;
                mac_addr           = cap_addr;
                mac_din            = merged;
            end else if (accept) begin
                tile_csb[req_tile] = 1'b0;
                mac_web            = !(req_wen && req_full);
            end
        end
    end

    for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
        logic [DATA_BIT-1:0] dout;
        assign tile_dout[t] = dout;
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            sram_macro_sp #(
                .DEPTH (MACRO_DEPTH)
            ) u_macro (
                .clk  (clk),
                .csb  (tile_csb[t]),
                .web  (mac_web),
                .addr (mac_addr),
                .din  (mac_din[b*MACRO_WIDTH +: MACRO_WIDTH]),
                .dout (dout[b*MACRO_WIDTH +: MACRO_WIDTH])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            rd_pending <= 1'b0;
            rd_tile    <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            cap_tile   <= '0;
            cap_addr   <= '0;
            cap_bwe    <= '0;
            cap_wdata  <= '0;
        end else begin
            // Read pipeline: macro read at accept, response registered one edge later.
            rd_pending <= accept && !req_wen;
            rd_tile    <= req_tile;
            rsp_valid  <= rd_pending;
            if (rd_pending) begin
                rsp_rdata <= tile_dout[rd_tile];
            end

            case (state)
                IDLE: begin
                    if (accept && req_wen && !req_full) begin
                        state     <= MERGE;
                        req_ready <= 1'b0;
                        cap_tile  <= req_tile;
                        cap_addr  <= req_addr[LAW-1:0];
                        cap_bwe   <= req_bwe;
                        cap_wdata <= req_wdata;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                MERGE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_tiled_rmw.sv
// Bench for sram_tiled_rmw: default build driven through a read scoreboard,
// plus a small BWE=0 build checked inline.
module tb_sram_tiled_rmw;
    import sram_pkg::*;

    localparam int DW       = 128;
    localparam int DEPTH    = 2048;
    localparam int AW       = 11;
    localparam int NB_DW    = 64;
    localparam int NB_DEPTH = 512;
    localparam int NB_AW    = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           req_valid, req_ready, req_wen, rsp_valid;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_bwe, req_wdata, rsp_rdata;
    state_t         dbg_state;

    logic              nb_req_valid, nb_req_ready, nb_req_wen, nb_rsp_valid;
    logic [NB_AW-1:0]  nb_req_addr;
    logic [NB_DW-1:0]  nb_req_bwe, nb_req_wdata, nb_rsp_rdata;
    state_t            nb_dbg_state;

    sram_tiled_rmw dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_bwe(req_bwe), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .dbg_state(dbg_state)
    );

    sram_tiled_rmw #(.DATA_BIT(NB_DW), .DEPTH(NB_DEPTH), .MACRO_DEPTH(128), .BWE(0)) dut_nb (
        .clk(clk), .rst(rst), .req_valid(nb_req_valid), .req_ready(nb_req_ready),
        .req_wen(nb_req_wen), .req_addr(nb_req_addr), .req_bwe(nb_req_bwe),
        .req_wdata(nb_req_wdata), .rsp_valid(nb_rsp_valid), .rsp_rdata(nb_rsp_rdata),
        .dbg_state(nb_dbg_state)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_count = 0;
    logic [DW-1:0] exp_q[$];
    int exp_cyc_q[$];
    logic [DW-1:0] mon_exp;
    int mon_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every response pops one expected word and its expected cycle.
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp got rdata=%h at cycle %0d, none expected", rsp_rdata, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                if (rsp_rdata !== mon_exp) begin
                    bad++;
                    $display("FAIL rsp_data got %h expected %h", rsp_rdata, mon_exp);
                end
                total++;
                if (cyc !== mon_cyc) begin
                    bad++;
                    $display("FAIL rsp_latency got cycle %0d expected %0d", cyc, mon_cyc);
                end
            end
        end
    end

    task automatic drive(input logic wen, input logic [AW-1:0] addr,
                         input logic [DW-1:0] bwe, input logic [DW-1:0] wdata);
        int w = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_bwe   = bwe;
        req_wdata = wdata;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got req_ready=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic commit();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_read(input logic [DW-1:0] exp);
        @(posedge clk);
        #1;
        exp_q.push_back(exp);
        exp_cyc_q.push_back(cyc + 1);
    endtask

    // Idle cycle with garbage in the payload fields, which must be ignored.
    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_wen   = 1'($urandom_range(0, 1));
        req_addr  = AW'($urandom_range(0, DEPTH - 1));
        req_bwe   = {$urandom, $urandom, $urandom, $urandom};
        req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 30) begin
            @(negedge clk);
            #1;
            w++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d outstanding responses expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_bwe = '0; req_wdata = '0;
        nb_req_valid = 1'b0; nb_req_wen = 1'b0; nb_req_addr = '0; nb_req_bwe = '0; nb_req_wdata = '0;
        repeat (3) @(negedge clk);
        total += 5;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b expected 0", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b expected 0", rsp_valid); end
        if (rsp_rdata !== '0) begin bad++; $display("FAIL reset_rdata got %h expected 0", rsp_rdata); end
        if (dut.tile_csb !== 4'b1111) begin bad++; $display("FAIL reset_csb got %b expected 1111", dut.tile_csb); end
        if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got %0d expected IDLE", dbg_state); end
        rst = 1'b0;
        @(negedge clk);
        total += 2;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got %b expected 1", req_ready); end
        if (nb_req_ready !== 1'b1) begin bad++; $display("FAIL nb_post_reset_ready got %b expected 1", nb_req_ready); end
    endtask

    task automatic test_full_write_read();
        logic [DW-1:0] v = {4{32'hAAAA_AAAA}};
        drive(1'b1, AW'(5), '1, v);
        commit();
        idle();
        total += 2;
        if (dbg_state !== IDLE) begin bad++; $display("FAIL full_write_state got %0d expected IDLE", dbg_state); end
        if (req_ready !== 1'b1) begin bad++; $display("FAIL full_write_ready got %b expected 1", req_ready); end
        drive(1'b0, AW'(5), '0, '0);
        commit_read(v);
        idle();
        drain();
    endtask

    task automatic test_partial_write();
        logic [DW-1:0] m = 128'h0000_00FF;
        drive(1'b1, AW'(600), '1, '1);
        commit();
        drive(1'b1, AW'(600), m, '0);
        commit();
        idle();
        total += 3;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL merge_ready got %b expected 0", req_ready); end
        if (dbg_state !== MERGE) begin bad++; $display("FAIL merge_state got %0d expected MERGE", dbg_state); end
        @(negedge clk);
        if (req_ready !== 1'b1) begin bad++; $display("FAIL after_merge_ready got %b expected 1", req_ready); end
        drive(1'b0, AW'(600), '0, '0);
        commit_read({{120{1'b1}}, 8'h00});
        idle();
        drain();
    endtask

    task automatic test_tile_isolation();
        logic [DW-1:0] v3 = {4{32'h0303_C0DE}};
        logic [DW-1:0] v5 = {4{32'h0515_BEEF}};
        drive(1'b1, AW'(3), '1, v3);
        #1;
        total++;
        if (dut.tile_csb !== 4'b1110) begin bad++; $display("FAIL csb_tile0 got %b expected 1110", dut.tile_csb); end
        commit();
        drive(1'b1, AW'(515), '1, v5);
        #1;
        total++;
        if (dut.tile_csb !== 4'b1101) begin bad++; $display("FAIL csb_tile1 got %b expected 1101", dut.tile_csb); end
        commit();
        idle();
        #1;
        total++;
        if (dut.tile_csb !== 4'b1111) begin bad++; $display("FAIL csb_idle got %b expected 1111", dut.tile_csb); end
        drive(1'b0, AW'(3), '0, '0);
        commit_read(v3);
        drive(1'b0, AW'(515), '0, '0);
        commit_read(v5);
        idle();
        drain();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] x = {$urandom, $urandom, $urandom, $urandom};
        logic [DW-1:0] m = {$urandom, $urandom, $urandom, $urandom};
        logic [DW-1:0] w = {$urandom, $urandom, $urandom, $urandom};
        int start;
        m[0] = 1'b0;
        drive(1'b1, AW'(1000), '1, x);
        commit();
        idle();
        drain();
        start = rsp_count;
        drive(1'b0, AW'(1000), '0, '0);
        commit_read(x);
        drive(1'b1, AW'(1000), m, w);
        commit();
        drive(1'b0, AW'(1000), '0, '0);
        commit_read((x & ~m) | (w & m));
        idle();
        drain();
        repeat (3) @(negedge clk);
        total++;
        if (rsp_count - start !== 2) begin
            bad++;
            $display("FAIL b2b_pulses got %0d expected 2", rsp_count - start);
        end
    endtask

    task automatic test_random();
        int addrs[8] = '{0, 1, 511, 512, 1023, 1536, 2047, 700};
        logic [DW-1:0] model [8];
        for (int i = 0; i < 8; i++) begin
            model[i] = {$urandom, $urandom, $urandom, $urandom};
            drive(1'b1, AW'(addrs[i]), '1, model[i]);
            commit();
        end
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 7);
            int op = $urandom_range(0, 2);
            logic [DW-1:0] m = {$urandom, $urandom, $urandom, $urandom};
            logic [DW-1:0] w = {$urandom, $urandom, $urandom, $urandom};
            if (op == 0) begin
                drive(1'b0, AW'(addrs[k]), '0, '0);
                commit_read(model[k]);
            end else if (op == 1) begin
                drive(1'b1, AW'(addrs[k]), '1, w);
                commit();
                model[k] = w;
            end else begin
                drive(1'b1, AW'(addrs[k]), m, w);
                commit();
                model[k] = (model[k] & ~m) | (w & m);
            end
            if ($urandom_range(0, 3) == 0) idle();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, AW'(addrs[i]), '0, '0);
            commit_read(model[i]);
        end
        idle();
        drain();
    endtask

    task automatic test_reset_merge();
        logic [DW-1:0] old = 128'h1234;
        drive(1'b1, AW'(7), '1, old);
        commit();
        drive(1'b0, AW'(7), '0, '0);
        commit();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL inflight_rsp got %b expected 0", rsp_valid); end
        end
        rst = 1'b0;
        drive(1'b1, AW'(7), {{96{1'b0}}, 32'hFFFF_0000}, '1);
        commit();
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if (dbg_state !== MERGE) begin bad++; $display("FAIL rst_merge_pre got %0d expected MERGE", dbg_state); end
        rst = 1'b1;
        @(negedge clk);
        total += 3;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_merge_rsp got %b expected 0", rsp_valid); end
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_merge_ready got %b expected 0", req_ready); end
        if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_merge_state got %0d expected IDLE", dbg_state); end
        rst = 1'b0;
        drive(1'b0, AW'(7), '0, '0);
        commit_read(old);
        idle();
        drain();
    endtask

    task automatic test_bwe0();
        logic [NB_DW-1:0] v = {2{32'h5555_5555}};
        @(negedge clk);
        nb_req_valid = 1'b1; nb_req_wen = 1'b1; nb_req_addr = NB_AW'(NB_DEPTH - 1);
        nb_req_bwe = '1; nb_req_wdata = '1;
        @(negedge clk);
        nb_req_bwe = 64'h0000_0000_0000_00FF; nb_req_wdata = v;
        @(negedge clk);
        nb_req_valid = 1'b0;
        total += 2;
        if (nb_req_ready !== 1'b1) begin bad++; $display("FAIL nb_ready got %b expected 1", nb_req_ready); end
        if (nb_dbg_state !== IDLE) begin bad++; $display("FAIL nb_state got %0d expected IDLE", nb_dbg_state); end
        @(negedge clk);
        nb_req_valid = 1'b1; nb_req_wen = 1'b0;
        @(negedge clk);
        nb_req_valid = 1'b0;
        total++;
        if (nb_rsp_valid !== 1'b0) begin bad++; $display("FAIL nb_early_rsp got %b expected 0", nb_rsp_valid); end
        @(negedge clk);
        total += 2;
        if (nb_rsp_valid !== 1'b1) begin bad++; $display("FAIL nb_rsp_valid got %b expected 1", nb_rsp_valid); end
        if (nb_rsp_rdata !== v) begin bad++; $display("FAIL nb_rdata got %h expected %h", nb_rsp_rdata, v); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_tile_isolation();
        test_back_to_back();
        test_random();
        test_reset_merge();
        test_bwe0();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
